sprite_line_engine: RTL and testbench

Parametrised per-scanline sprite engine for the PPU: during horizontal blanking it scans OAM for sprites covering the next line, fetches their pattern rows from sprite graphics memory, and during the active line produces one prioritised sprite pixel per pixel strobe. It replaces the fixed shift-register block and sprite priority encoder with a single unit whose sprite count, per-line capacity, sprite size and colour depth are parameters. Its pixel output feeds the background/sprite mixer ahead of the palette lookup and VGA controller.

---
 rtl/sprite_line_engine.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_engine.sv
// sprite_line_engine
// Per-scanline sprite engine. On line_start it scans every OAM entry for
// sprites covering line_num (EVAL), fetches the pattern row of each matched
// sprite from graphics memory (FETCH), then returns to IDLE and emits one
// prioritised sprite pixel per pixel strobe for the active line.
//
// Optional feature: define SPRITE_FLIP_EN to honour the OAM hflip/vflip bits.
// Without it OAM bits 30/31 are ignored and rows/pixels are never reversed.
//
// Ports
//   clk, reset         system clock, synchronous active-low reset
//   line_start         one-cycle pulse: evaluate sprites for line_num
//   line_num           scanline being prepared
//   oam_addr/oam_rd    OAM read port request; oam_data valid one cycle later
//   gfx_addr/gfx_rd    pattern memory request {tile,row}; gfx_data one cycle later
//   pixel_en, hcount   pixel strobe and current pixel X
//   spr_valid/spr_pixel/spr_palette/spr_behind  winning sprite pixel (registered)
//   busy               evaluation or fetch in progress
//   line_overflow      more than MAX_PER_LINE sprites matched the last line
module sprite_line_engine #(
  parameter int unsigned NUM_SPRITES  = 64,
  parameter int unsigned MAX_PER_LINE = 8,
  parameter int unsigned SPRITE_W     = 16,
  parameter int unsigned SPRITE_H     = 16,
  parameter int unsigned BPP          = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            line_start,
  input  logic [9:0]                      line_num,
  output logic [$clog2(NUM_SPRITES)-1:0]  oam_addr,
  output logic                            oam_rd,
  input  logic [31:0]                     oam_data,
  output logic [6+$clog2(SPRITE_H)-1:0]   gfx_addr,
  output logic                            gfx_rd,
  input  logic [SPRITE_W*BPP-1:0]         gfx_data,
  input  logic                            pixel_en,
  input  logic [9:0]                      hcount,
  output logic                            spr_valid,
  output logic [BPP-1:0]                  spr_pixel,
  output logic [2:0]                      spr_palette,
  output logic                            spr_behind,
  output logic                            busy,
  output logic                            line_overflow
);

  localparam int unsigned AW = $clog2(NUM_SPRITES);
  localparam int unsigned RW = $clog2(SPRITE_H);
  localparam int unsigned GW = 6 + RW;
  localparam int unsigned PW = SPRITE_W * BPP;
  localparam int unsigned SW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam int unsigned FW = $clog2(MAX_PER_LINE + 1);
  localparam int unsigned CW = $clog2(NUM_SPRITES + MAX_PER_LINE + 2);

  typedef enum logic [1:0] {IDLE, EVAL, FETCH} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            busy_d, oam_rd_d, gfx_rd_d;
  logic [AW-1:0]   oam_addr_d;
  logic [GW-1:0]   gfx_addr_d;
  logic            oam_vld, gfx_vld;

  // Per-slot sprite state for the line being displayed
  logic [MAX_PER_LINE-1:0] slot_vld;
  logic [MAX_PER_LINE-1:0] slot_beh;
  logic [9:0]              slot_x    [MAX_PER_LINE];
  logic [5:0]              slot_tile [MAX_PER_LINE];
  logic [RW-1:0]           slot_row  [MAX_PER_LINE];
  logic [2:0]              slot_pal  [MAX_PER_LINE];
  logic [PW-1:0]           slot_pix  [MAX_PER_LINE];
`ifdef SPRITE_FLIP_EN
  logic [MAX_PER_LINE-1:0] slot_hf;
`else
  logic                    unused_flip;
  assign unused_flip = ^oam_data[31:30];
`endif
  logic [FW-1:0]           fill;

  logic [9:0]      d;
  logic            match, full, slot_wr, ovf_set, cap_en, clr;
  logic [RW-1:0]   new_row;
  logic [SW-1:0]   wr_idx, cap_idx, rd_idx;
  logic [PW-1:0]   cap_pix;

  // Line match test and row selection for the OAM word returned this cycle
  always_comb begin
    d     = line_num - oam_data[19:10];
    match = d < 10'(SPRITE_H);
`ifdef SPRITE_FLIP_EN
    new_row = oam_data[31] ? ~d[RW-1:0] : d[RW-1:0];
`else
    new_row = d[RW-1:0];
`endif
    full    = fill == FW'(MAX_PER_LINE);
    wr_idx  = SW'(fill);
    cap_idx = SW'(cnt - CW'(1));
    rd_idx  = SW'(cnt + CW'(1));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    busy_d     = busy;
    oam_rd_d   = 1'b0;
    oam_addr_d = '0;
    gfx_rd_d   = 1'b0;
    gfx_addr_d = '0;
    slot_wr    = 1'b0;
    ovf_set    = 1'b0;
    cap_en     = 1'b0;
    clr        = 1'b0;
    if (line_start) begin
      clr      = 1'b1;
      state_d  = EVAL;
      cnt_d    = '0;
      busy_d   = 1'b1;
      oam_rd_d = 1'b1;
    end else begin
      case (state)
        EVAL: begin
          slot_wr = oam_vld && match && !full;
          ovf_set = oam_vld && match && full;
          if (cnt < CW'(NUM_SPRITES - 1)) begin
            oam_rd_d   = 1'b1;
            oam_addr_d = AW'(cnt + CW'(1));
            cnt_d      = cnt + CW'(1);
          end else if (cnt == CW'(NUM_SPRITES - 1)) begin
            cnt_d = cnt + CW'(1);
          end else begin
            // Final compare cycle: slot 0 may be written right now, so bypass it
            state_d  = FETCH;
            cnt_d    = '0;
            gfx_rd_d = slot_wr || (fill != '0);
            if (slot_wr && (fill == '0)) gfx_addr_d = {oam_data[25:20], new_row};
            else                         gfx_addr_d = {slot_tile[0], slot_row[0]};
          end
        end
        FETCH: begin
          // cnt counts fetch cycles; data for slot cnt-1 arrives this cycle
          cap_en = gfx_vld;
          if (cnt == CW'(fill)) begin
            state_d = IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt + CW'(1);
            if ((cnt + CW'(1)) < CW'(fill)) begin
              gfx_rd_d   = 1'b1;
              gfx_addr_d = {slot_tile[rd_idx], slot_row[rd_idx]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register and memory request outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      oam_rd   <= 1'b0;
      oam_addr <= '0;
      gfx_rd   <= 1'b0;
      gfx_addr <= '0;
      oam_vld  <= 1'b0;
      gfx_vld  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      busy     <= busy_d;
      oam_rd   <= oam_rd_d;
      oam_addr <= oam_addr_d;
      gfx_rd   <= gfx_rd_d;
      gfx_addr <= gfx_addr_d;
      // A restart drops any read still in flight
      oam_vld  <= oam_rd && !line_start;
      gfx_vld  <= gfx_rd && !line_start;
    end
  end

  // Pattern row as stored in the slot: pixel 0 in LSBs, mirrored for hflip
  always_comb begin
    cap_pix = gfx_data;
`ifdef SPRITE_FLIP_EN
    if (slot_hf[cap_idx]) begin
      for (int p = 0; p < int'(SPRITE_W); p++)
        cap_pix[p*int'(BPP) +: BPP] = gfx_data[(int'(SPRITE_W)-1-p)*int'(BPP) +: BPP];
    end
`endif
  end

  // Slot storage, fill count and overflow flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill          <= '0;
      line_overflow <= 1'b0;
      slot_vld      <= '0;
      slot_beh      <= '0;
`ifdef SPRITE_FLIP_EN
      slot_hf       <= '0;
`endif
      for (int k = 0; k < int'(MAX_PER_LINE); k++) begin
        slot_x[k]    <= '0;
        slot_tile[k] <= '0;
        slot_row[k]  <= '0;
        slot_pal[k]  <= '0;
        slot_pix[k]  <= '0;
      end
    end else if (clr) begin
      fill          <= '0;
      line_overflow <= 1'b0;
      slot_vld      <= '0;
    end else begin
      if (slot_wr) begin
        slot_x[wr_idx]    <= oam_data[9:0];
        slot_tile[wr_idx] <= oam_data[25:20];
        slot_row[wr_idx]  <= new_row;
        slot_pal[wr_idx]  <= oam_data[28:26];
        slot_beh[wr_idx]  <= oam_data[29];
`ifdef SPRITE_FLIP_EN
        slot_hf[wr_idx]   <= oam_data[30];
`endif
        fill <= fill + FW'(1);
      end
      if (ovf_set) line_overflow <= 1'b1;
      if (cap_en) begin
        slot_pix[cap_idx] <= cap_pix;
        slot_vld[cap_idx] <= 1'b1;
      end
    end
  end

  logic [9:0]     off;
  logic [BPP-1:0] pv;
  logic           hit_d, beh_d;
  logic [BPP-1:0] pix_d;
  logic [2:0]     pal_d;

  // Priority pick: scan high to low so the lowest opaque slot wins
  always_comb begin
    hit_d = 1'b0;
    pix_d = '0;
    pal_d = '0;
    beh_d = 1'b0;
    off   = '0;
    pv    = '0;
    for (int k = int'(MAX_PER_LINE) - 1; k >= 0; k--) begin
      off = hcount - slot_x[k];
      pv  = BPP'(slot_pix[k] >> (32'(off) * BPP));
      if (slot_vld[k] && (off < 10'(SPRITE_W)) && (pv != '0)) begin
        hit_d = 1'b1;
        pix_d = pv;
        pal_d = slot_pal[k];
        beh_d = slot_beh[k];
      end
    end
    if (busy || !pixel_en) begin
      hit_d = 1'b0;
      pix_d = '0;
      pal_d = '0;
      beh_d = 1'b0;
    end
  end

  // Registered pixel outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      spr_valid   <= 1'b0;
      spr_pixel   <= '0;
      spr_palette <= '0;
      spr_behind  <= 1'b0;
    end else begin
      spr_valid   <= hit_d;
      spr_pixel   <= pix_d;
      spr_palette <= pal_d;
      spr_behind  <= beh_d;
    end
  end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Testbench for sprite_line_engine: OAM and pattern memories are modelled as
// one-cycle-latency arrays; a line-level reference model derives the expected
// matches, fetch addresses, overflow and pixels from the OAM contents.
`timescale 1ns/1ps
module tb_sprite_line_engine;
  localparam int NS = 64, MPL = 8, SW = 16, SH = 16, BPP = 2;
`ifdef SPRITE_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0, line_start = 1'b0, pixel_en = 1'b0;
  logic [9:0]  line_num = '0, hcount = '0;
  logic [5:0]  oam_addr;
  logic        oam_rd;
  logic [31:0] oam_data = '0;
  logic [9:0]  gfx_addr;
  logic        gfx_rd;
  logic [31:0] gfx_data = '0;
  logic        spr_valid, spr_behind, busy, line_overflow;
  logic [1:0]  spr_pixel;
  logic [2:0]  spr_palette;

  logic [31:0] oam_mem [NS];
  logic [31:0] gfx_mem [1024];
  int chk_total = 0, chk_pass = 0;

  sprite_line_engine #(.NUM_SPRITES(NS), .MAX_PER_LINE(MPL), .SPRITE_W(SW),
                       .SPRITE_H(SH), .BPP(BPP)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
    .oam_addr(oam_addr), .oam_rd(oam_rd), .oam_data(oam_data),
    .gfx_addr(gfx_addr), .gfx_rd(gfx_rd), .gfx_data(gfx_data),
    .pixel_en(pixel_en), .hcount(hcount),
    .spr_valid(spr_valid), .spr_pixel(spr_pixel), .spr_palette(spr_palette),
    .spr_behind(spr_behind), .busy(busy), .line_overflow(line_overflow));

  always #5 clk = ~clk;

  // Synchronous-read memories
  always @(posedge clk) begin
    if (oam_rd) oam_data <= oam_mem[oam_addr];
    if (gfx_rd) gfx_data <= gfx_mem[gfx_addr];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_total++;
    if (got === exp) chk_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] mk_oam(input int x, y, tile, pal, input bit beh, hf, vf);
    return {vf, hf, beh, 3'(pal), 6'(tile), 10'(y), 10'(x)};
  endfunction

  task automatic clear_oam();
    for (int e = 0; e < NS; e++) oam_mem[e] = mk_oam(0, 600, 0, 0, 0, 0, 0);
  endtask

  // Reference model of one evaluated line
  int m_n;
  bit m_ovf;
  int m_x [MPL], m_tile [MPL], m_row [MPL], m_pal [MPL], m_beh [MPL], m_hf [MPL];

  task automatic model_line(input int ln);
    m_n = 0;
    m_ovf = 0;
    for (int e = 0; e < NS; e++) begin
      logic [31:0] w;
      int x, y, dd;
      w  = oam_mem[e];
      x  = int'(w[9:0]);
      y  = int'(w[19:10]);
      dd = (ln - y + 1024) % 1024;
      if (dd < SH) begin
        if (m_n < MPL) begin
          m_x[m_n]    = x;
          m_tile[m_n] = int'(w[25:20]);
          m_pal[m_n]  = int'(w[28:26]);
          m_beh[m_n]  = int'(w[29]);
          m_hf[m_n]   = (FLIP && w[30]) ? 1 : 0;
          m_row[m_n]  = (FLIP && w[31]) ? SH - 1 - dd : dd;
          m_n++;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  function automatic logic [6:0] model_pix(input int h);
    for (int k = 0; k < m_n; k++) begin
      int o;
      o = (h - m_x[k] + 1024) % 1024;
      if (o < SW) begin
        logic [31:0] rowd;
        int idx, pvv;
        rowd = gfx_mem[m_tile[k] * SH + m_row[k]];
        idx  = (m_hf[k] != 0) ? SW - 1 - o : o;
        pvv  = int'((rowd >> (idx * BPP)) & 32'd3);
        if (pvv != 0) return {1'b1, 1'(m_beh[k]), 3'(m_pal[k]), 2'(pvv)};
      end
    end
    return 7'd0;
  endfunction

  int got_cyc;
  int got_addr [$];

  // Pulse line_start and follow the busy window, recording fetch addresses
  task automatic run_line(input int ln);
    @(negedge clk);
    line_start = 1'b1;
    line_num   = 10'(ln);
    @(negedge clk);
    line_start = 1'b0;
    got_cyc = 0;
    got_addr.delete();
    while (busy && got_cyc < 400) begin
      if (gfx_rd) got_addr.push_back(int'(gfx_addr));
      got_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_line(input int ln, input string nm);
    model_line(ln);
    check({nm, "_busy_cycles"}, got_cyc, NS + 1 + m_n + 1);
    check({nm, "_overflow"}, 32'(line_overflow), 32'(m_ovf));
    check({nm, "_fetch_count"}, got_addr.size(), m_n);
    for (int k = 0; k < m_n && k < got_addr.size(); k++)
      check({nm, "_fetch_addr"}, got_addr[k], m_tile[k] * SH + m_row[k]);
  endtask

  task automatic check_pix(input int h, input string nm);
    logic [6:0] exp;
    hcount   = 10'(h);
    pixel_en = 1'b1;
    @(posedge clk);
    #1;
    exp = model_pix(h);
    check(nm, {spr_valid, spr_behind, spr_palette, spr_pixel}, exp);
  endtask

  typedef struct {
    int y;
    int ln;
    bit vf;
    bit hit;
    int row_nf;
    int row_f;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int n, ln, spread, h, k;
    vecs[0] = '{50,   52,   1'b0, 1'b1, 2,  2};
    vecs[1] = '{1020, 5,    1'b0, 1'b1, 9,  9};
    vecs[2] = '{1020, 12,   1'b0, 1'b0, 0,  0};
    vecs[3] = '{1020, 1023, 1'b0, 1'b1, 3,  3};
    vecs[4] = '{0,    15,   1'b0, 1'b1, 15, 15};
    vecs[5] = '{0,    16,   1'b0, 1'b0, 0,  0};
    vecs[6] = '{100,  99,   1'b0, 1'b0, 0,  0};
    vecs[7] = '{40,   52,   1'b1, 1'b1, 12, 3};

    for (int i = 0; i < 1024; i++) gfx_mem[i] = (i % 2 == 0) ? $urandom() : ($urandom() & $urandom());
    clear_oam();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {spr_valid, spr_pixel, spr_palette, spr_behind, busy, line_overflow,
                            oam_rd, gfx_rd, oam_addr, gfx_addr}, 32'd0);
    reset = 1'b1;

    // Single-sprite match table, sprite in entry 0 with tile 3
    for (int i = 0; i < 8; i++) begin
      clear_oam();
      oam_mem[0] = mk_oam(100, vecs[i].y, 3, 1, 0, 0, vecs[i].vf);
      run_line(vecs[i].ln);
      check("vec_busy_cycles", got_cyc, 66 + int'(vecs[i].hit));
      check("vec_fetch_count", got_addr.size(), int'(vecs[i].hit));
      if (vecs[i].hit && got_addr.size() > 0)
        check("vec_fetch_addr", got_addr[0], 3 * SH + (FLIP ? vecs[i].row_f : vecs[i].row_nf));
    end

    // Single sprite pixel sweep across its span
    clear_oam();
    oam_mem[0] = mk_oam(100, 50, 3, 4, 1, 0, 0);
    gfx_mem[50] = 32'hE4E4_1B1B;
    run_line(52);
    check_line(52, "single");
    for (int hh = 98; hh <= 117; hh++) begin
      check_pix(hh, "single_pix");
      if (hh == 99 || hh == 116) check("single_edge_valid", 32'(spr_valid), 32'd0);
    end
    hcount = 10'd101;
    pixel_en = 1'b0;
    @(posedge clk);
    #1;
    check("pixel_en_low", {spr_valid, spr_behind, spr_palette, spr_pixel}, 32'd0);

    // Ten sprites on one line: eight slots, overflow
    clear_oam();
    for (int e = 0; e < 10; e++) oam_mem[e] = mk_oam(e * 20, 10, e, e % 8, 0, 0, 0);
    run_line(10);
    check_line(10, "ten");
    check("ten_busy_74", got_cyc, 74);
    check("ten_overflow", 32'(line_overflow), 32'd1);
    for (int i = 0; i < 6; i++) check_pix(i * 30 + 3, "ten_pix");
    pixel_en = 1'b0;

    // Priority between overlapping sprites 2 and 5
    clear_oam();
    oam_mem[2] = mk_oam(195, 300, 4, 2, 0, 0, 0);
    oam_mem[5] = mk_oam(190, 300, 5, 5, 1, 0, 0);
    gfx_mem[64] = 32'h5555_5555;
    gfx_mem[80] = 32'hAAAA_AAAA;
    run_line(300);
    check_line(300, "prio");
    check_pix(200, "prio_pix");
    check("prio_low_wins", 32'(spr_palette), 32'd2);
    gfx_mem[64] = 32'h5555_5155;
    run_line(300);
    check_pix(200, "prio_pix2");
    check("prio_transparent", {spr_palette, spr_pixel, spr_behind}, {3'd5, 2'd2, 1'b1});
    pixel_en = 1'b0;

    // hflip + vflip at d=0
    clear_oam();
    oam_mem[0] = mk_oam(300, 400, 9, 6, 0, 1, 1);
    gfx_mem[159] = 32'hC000_0001;
    gfx_mem[144] = 32'h8000_0002;
    run_line(400);
    check_line(400, "flip");
    if (got_addr.size() > 0) check("flip_addr", got_addr[0], FLIP ? 159 : 144);
    check_pix(300, "flip_pix");
    check("flip_pixel", 32'(spr_pixel), FLIP ? 32'd3 : 32'd2);
    pixel_en = 1'b0;

    // Restart mid-EVAL
    ln = 700;
    clear_oam();
    for (int e = 0; e < NS; e++)
      oam_mem[e] = mk_oam($urandom_range(0, 300), (ln - $urandom_range(0, 60)) & 1023,
                          $urandom_range(0, 63), $urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);
    line_start = 1'b1;
    line_num   = 10'd100;
    @(negedge clk);
    line_start = 1'b0;
    repeat (20) @(negedge clk);
    run_line(ln);
    check_line(ln, "restart");
    for (int i = 0; i < 10; i++) begin
      k = (m_n > 0) ? $urandom_range(0, m_n - 1) : 0;
      check_pix((m_x[k] + $urandom_range(0, 17)) & 1023, "restart_pix");
    end
    pixel_en = 1'b0;

    // Reset mid-FETCH
    clear_oam();
    for (int e = 0; e < 10; e++) oam_mem[e] = mk_oam(e * 20, 10, e, 3, 1, 0, 0);
    @(negedge clk);
    line_start = 1'b1;
    line_num   = 10'd10;
    @(negedge clk);
    line_start = 1'b0;
    n = 0;
    while (!gfx_rd && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("rst_reached_fetch", 32'(gfx_rd), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_fetch_outputs", {spr_valid, spr_pixel, spr_palette, spr_behind, busy, line_overflow,
                                    oam_rd, gfx_rd, oam_addr, gfx_addr}, 32'd0);
    reset = 1'b1;
    m_n = 0;
    check_pix(5, "rst_slots_invalid");
    pixel_en = 1'b0;
    run_line(10);
    check_line(10, "rst_recover");

    // Randomised lines against the reference model
    for (int t = 0; t < 8; t++) begin
      ln = $urandom_range(0, 1023);
      spread = (t % 4 == 0) ? 20 : (t % 4 == 1) ? 60 : (t % 4 == 2) ? 300 : 1023;
      for (int e = 0; e < NS; e++)
        oam_mem[e] = mk_oam((t < 4) ? $urandom_range(0, 200) : $urandom_range(0, 1023),
                            (ln - $urandom_range(0, spread)) & 1023, $urandom_range(0, 63),
                            $urandom_range(0, 7), 1'($urandom), 1'($urandom), 1'($urandom));
      run_line(ln);
      check_line(ln, "rand");
      for (int i = 0; i < 30; i++) begin
        if (m_n > 0 && (i % 3) != 0) begin
          k = $urandom_range(0, m_n - 1);
          h = (m_x[k] + $urandom_range(0, 17) + 1023) & 1023;
        end else begin
          h = $urandom_range(0, 1023);
        end
        check_pix(h, "rand_pix");
      end
      pixel_en = 1'b0;
    end

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
